// File: rtl/dmem_mmio.sv
// dmem_mmio: word RAM plus LED/switch/timer I/O page on the processor data port.
// Reads are combinational; writes and all I/O state update on the rising clock edge.
module dmem_mmio #(
    parameter int DEPTH    = 64,
    parameter int PRESCALE = 50000,
    parameter int SW_W     = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [31:0]     a,
    input  logic [31:0]     wd,
    output logic [31:0]     rd,
    input  logic [SW_W-1:0] sw,
    output logic [SW_W-1:0] ledr,
    output logic            irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [31:0]     mem [DEPTH];
    logic [SW_W-1:0] led_q, led_d, sw1_q, sw2_q;
    logic [31:0]     count_q, count_d, cmp_q, cmp_d, io_rd;
    logic [PW-1:0]   pre_q, pre_d;
    logic            flag_q, flag_d;
    logic            ram_sel, io_sel, tick, match;
    logic            wr_led, wr_count, wr_cmp, wr_status;
    logic [2:0]      rsel;

    assign ram_sel   = a[31:AW+2] == '0;
    assign io_sel    = a[31:5] == 27'h7FFF800;
    assign rsel      = a[4:2];
    assign wr_led    = we && io_sel && rsel == 3'd0;
    assign wr_count  = we && io_sel && rsel == 3'd2;
    assign wr_cmp    = we && io_sel && rsel == 3'd3;
    assign wr_status = we && io_sel && rsel == 3'd4;
    assign tick      = pre_q == PRE_MAX;
    assign match     = cmp_q != '0 && count_q == cmp_q;

    assign io_rd = rsel == 3'd0 ? {{(32-SW_W){1'b0}}, led_q} :
                   rsel == 3'd1 ? {{(32-SW_W){1'b0}}, sw2_q} :
                   rsel == 3'd2 ? count_q :
                   rsel == 3'd3 ? cmp_q :
                   rsel == 3'd4 ? {31'b0, flag_q} : '0;
    assign rd    = ram_sel ? mem[a[AW+1:2]] : io_sel ? io_rd : '0;
    assign ledr  = led_q;
    assign irq   = flag_q;

    always_ff @(posedge clk)
        if (we && ram_sel && !reset) mem[a[AW+1:2]] <= wd;

    // A CPU write to COUNT swallows a coincident tick, including its match.
    always_comb begin
        pre_d   = tick ? '0 : pre_q + 1'b1;
        led_d   = wr_led ? wd[SW_W-1:0] : led_q;
        cmp_d   = wr_cmp ? wd : cmp_q;
        count_d = wr_count ? wd : !tick ? count_q : match ? '0 : count_q + 32'd1;
        flag_d  = (tick && match && !wr_count) || (flag_q && !(wr_status && wd[0]));
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            led_q   <= '0;
            sw1_q   <= '0;
            sw2_q   <= '0;
            count_q <= '0;
            cmp_q   <= '0;
            pre_q   <= '0;
            flag_q  <= 1'b0;
        end else begin
            led_q   <= led_d;
            sw1_q   <= sw;
            sw2_q   <= sw1_q;
            count_q <= count_d;
            cmp_q   <= cmp_d;
            pre_q   <= pre_d;
            flag_q  <= flag_d;
        end
endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed checks of RAM, LED/switch registers, timer, collisions and async reset.
module tb_dmem_mmio;
    localparam logic [31:0] LED = 32'hFFFF0000, SW = 32'hFFFF0004, CNT = 32'hFFFF0008,
                            CMP = 32'hFFFF000C, STS = 32'hFFFF0010;

    logic        clk = 1'b0, reset = 1'b1, we = 1'b0, irq;
    logic [31:0] a = '0, wd = '0, rd;
    logic [9:0]  sw = '0, ledr;
    int          errors = 0, checks = 0, cyc = 0;

    dmem_mmio #(.DEPTH(64), .PRESCALE(4), .SW_W(10)) dut (
        .clk(clk), .reset(reset), .we(we), .a(a), .wd(wd), .rd(rd),
        .sw(sw), .ledr(ledr), .irq(irq)
    );

    always #5 clk = ~clk;

    // Edges since the last reset; the prescaler ticks on every edge where this becomes a multiple of 4.
    always @(posedge clk or posedge reset)
        if (reset) cyc <= 0;
        else cyc <= cyc + 1;

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        we = 1'b1; a = addr; wd = data;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic align(input int k);
        for (int i = 0; i < 8 && (cyc % 4) != k; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        #2;
        checks++; if (ledr !== 10'h0) begin errors++; $display("FAIL reset_ledr got=%h exp=000", ledr); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
        a = CNT; #1;
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_count got=%h exp=00000000", rd); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_ram;
        wr(32'h14, 32'h12345678);
        wr(32'h00, 32'h0BAD0000);
        wr(32'h10, 32'hDEADBEEF);
        wr(32'hFC, 32'hA5A5A5A5);
        wr(32'h100, 32'hCAFEF00D);
        a = 32'h10; #1;
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_10 got=%h exp=deadbeef", rd); end
        a = 32'h13; #1;
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_13 got=%h exp=deadbeef", rd); end
        a = 32'h14; #1;
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL ram_14 got=%h exp=12345678", rd); end
        a = 32'hFC; #1;
        checks++; if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL ram_top got=%h exp=a5a5a5a5", rd); end
        a = 32'h0; #1;
        checks++; if (rd !== 32'h0BAD0000) begin errors++; $display("FAIL ram_noalias got=%h exp=0bad0000", rd); end
        a = 32'h100; #1;
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ram_beyond got=%h exp=00000000", rd); end
        @(negedge clk);
        we = 1'b1; a = 32'h10; wd = 32'h11111111; #1;
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_rdw_old got=%h exp=deadbeef", rd); end
        @(negedge clk);
        we = 1'b0;
        checks++; if (rd !== 32'h11111111) begin errors++; $display("FAIL ram_rdw_new got=%h exp=11111111", rd); end
        a = 32'h80000000; #1;
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL unmapped got=%h exp=00000000", rd); end
        @(negedge clk);
    endtask

    task automatic test_led_sw;
        wr(LED, 32'h3A5);
        checks++; if (ledr !== 10'h3A5) begin errors++; $display("FAIL led_out got=%h exp=3a5", ledr); end
        wr(LED, 32'hFFFFFFFF);
        a = LED; #1;
        checks++; if (rd !== 32'h3FF) begin errors++; $display("FAIL led_read got=%h exp=000003ff", rd); end
        @(negedge clk);
        sw = 10'h155; a = SW;
        @(negedge clk);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sw_1cyc got=%h exp=00000000", rd); end
        @(negedge clk);
        checks++; if (rd !== 32'h155) begin errors++; $display("FAIL sw_2cyc got=%h exp=00000155", rd); end
        wr(SW, 32'h0);
        a = SW; #1;
        checks++; if (rd !== 32'h155) begin errors++; $display("FAIL sw_readonly got=%h exp=00000155", rd); end
        @(negedge clk);
    endtask

    task automatic test_timer;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wr(CMP, 32'd3);
        a = CMP; #1;
        checks++; if (rd !== 32'd3) begin errors++; $display("FAIL cmp_read got=%h exp=00000003", rd); end
        a = CNT;
        for (int k = 1; k <= 3; k++) begin
            repeat (4) @(negedge clk);
            if (k == 1) repeat (0) @(negedge clk);
            checks++; if (rd !== k) begin errors++; $display("FAIL count_step%0d got=%h exp=%h", k, rd, k); end
        end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_before_match got=%b exp=0", irq); end
        repeat (4) @(negedge clk);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL count_match got=%h exp=00000000", rd); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_match got=%b exp=1", irq); end
        wr(STS, 32'h0);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL status_w0 got=%b exp=1", irq); end
        a = STS; #1;
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL status_read got=%h exp=00000001", rd); end
        @(negedge clk);
        wr(STS, 32'hFFFFFFFF);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL status_w1 got=%b exp=0", irq); end
    endtask

    task automatic test_collisions;
        align(3);
        wr(CNT, 32'h100);
        a = CNT; #1;
        checks++; if (rd !== 32'h100) begin errors++; $display("FAIL count_wr_on_tick got=%h exp=00000100", rd); end
        @(negedge clk);
        wr(CNT, 32'd3);
        align(3);
        wr(STS, 32'h1);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL clear_on_match got=%b exp=1", irq); end
        a = CNT; #1;
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL clear_on_match_count got=%h exp=00000000", rd); end
        @(negedge clk);
    endtask

    task automatic test_wrap;
        wr(STS, 32'h1);
        wr(CMP, 32'h0);
        align(2);
        wr(CNT, 32'hFFFFFFFF);
        a = CNT; #1;
        checks++; if (rd !== 32'hFFFFFFFF) begin errors++; $display("FAIL wrap_pre got=%h exp=ffffffff", rd); end
        align(0);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wrap_count got=%h exp=00000000", rd); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL wrap_irq got=%b exp=0", irq); end
    endtask

    task automatic test_async_reset;
        align(0);
        wr(CMP, 32'd1);
        wr(CNT, 32'd1);
        align(0);
        wr(CNT, 32'd5);
        wr(LED, 32'h3FF);
        a = CNT; #1;
        checks++; if (rd !== 32'd5 || irq !== 1'b1 || ledr !== 10'h3FF)
            begin errors++; $display("FAIL arst_setup count=%h irq=%b ledr=%h exp=5/1/3ff", rd, irq, ledr); end
        #1;
        we = 1'b1; a = LED; wd = 32'h0AA; reset = 1'b1; #1;
        checks++; if (ledr !== 10'h0) begin errors++; $display("FAIL arst_ledr got=%h exp=000", ledr); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL arst_irq got=%b exp=0", irq); end
        a = CNT; #1;
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL arst_count got=%h exp=00000000", rd); end
        a = LED;
        @(negedge clk);
        reset = 1'b0; we = 1'b0; #1;
        checks++; if (ledr !== 10'h0) begin errors++; $display("FAIL arst_write_dropped got=%h exp=000", ledr); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_ram();
        test_led_sw();
        test_timer();
        test_collisions();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
Data-side responder for the single-cycle processor's load/store interface. It services every data access the datapath initiates: word-addressed RAM plus a small memory-mapped I/O page with LED register, synchronized switches, and a prescaled timer with compare flag. Reads are combinational so a load completes in the same cycle; writes commit on the rising clock edge.

Parameters:
DEPTH, 64, RAM size in 32-bit words (power of two).
PRESCALE, 50000, clock cycles per timer tick (>=1; default gives 1 ms at 50 MHz).
SW_W, 10, width of switch input and LED output.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
we  in  1  memwrite from controller; write commits at posedge clk
a  in  32  byte address (datapath aluout)
wd  in  32  write data (datapath writedata)
rd  out  32  read data to datapath readdata, combinational
sw  in  SW_W  board switches, asynchronous to clk
ledr  out  SW_W  LED register output
irq  out  1  timer match flag (sticky)

Behaviour:
- Reset: clk and reset as named above; reset is asynchronous, active-high. On reset: LED=0, switch sync flops=0, timer count=0, compare=0, prescaler=0, flag=0, so ledr=0 and irq=0. RAM is not reset and has undefined contents.
- Address decode ignores a[1:0], so all accesses are whole words.
- RAM region: a < 4*DEPTH, indexed by a[log2(DEPTH)+1:2].
- I/O page, a[31:5]==0xFFFF000>>1 equivalent (i.e. a[31:5] == 27'h7FFF800), register select a[4:2]:
  - 0xFFFF0000 LED: read/write, low SW_W bits, upper bits read 0.
  - 0xFFFF0004 SW: read-only; value = sw after 2-flop synchronizer (2-cycle latency); writes ignored.
  - 0xFFFF0008 COUNT: read/write timer count.
  - 0xFFFF000C CMP: read/write compare value.
  - 0xFFFF0010 STATUS: bit0 = flag, other bits read 0. Writing 1 to bit0 clears the flag; writing 0 has no effect.
- Any other address reads 0x00000000 and ignores writes.
- Read path: rd is a combinational function of a and current state with no clock latency. A read in the same cycle as a write to that location returns the old value.
- Prescaler: counts 0..PRESCALE-1 and wraps. A tick is asserted in the cycle where the prescaler equals PRESCALE-1.
- Timer on tick:
  - CMP != 0 and COUNT == CMP: COUNT <= 0, flag <= 1.
  - Otherwise: COUNT <= COUNT+1, wrapping 0xFFFFFFFF -> 0 with no flag.
  - CMP == 0 means the compare is disabled and the timer runs freely.
- Simultaneous events:
  - CPU write to COUNT on a tick cycle: the CPU value wins and the tick is lost.
  - STATUS clear on the same cycle as a match: the set wins and flag stays 1.
  - CPU write to CMP takes effect for the next tick.
- irq = flag, registered output.
- Reset asserted mid-operation clears all I/O state immediately, independent of clk. Writes presented during reset are dropped.

Test Plan:
- RAM: write 0xDEADBEEF to 0x00000010, then read 0x00000010 and 0x00000013 -> both return 0xDEADBEEF; read 0x00000014 returns the value written there earlier.
- LED/SW: write 0x3A5 to 0xFFFF0000 -> ledr=0x3A5 on the next cycle. Set sw=0x155 -> read 0xFFFF0004 returns the old value 1 cycle later and 0x155 after 2 cycles; a write to 0xFFFF0004 changes nothing.
- Timer with PRESCALE=4, CMP=3: COUNT steps 1,2,3 on ticks at cycles 4,8,12; the tick at cycle 16 sets COUNT=0 and irq=1. Writing 1 to 0xFFFF0010 clears irq; writing 0 leaves irq unchanged.
- Collisions:
  - Write COUNT=0x100 on a tick cycle -> COUNT reads 0x100, not 0x101.
  - STATUS clear on a match cycle -> irq stays 1.
- Wrap: CMP=0, write COUNT=0xFFFFFFFF, next tick -> COUNT=0 and irq stays 0. Unmapped read at 0x80000000 returns 0.
- Async reset: with LED=0x3FF, irq=1 and COUNT=5, pulse reset between clock edges -> ledr=0, irq=0 and COUNT=0 before the next edge; a write with we=1 during reset is dropped.
